// File: rtl/sfcw_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sfcw_pkg
// Description : Shared definitions for the SFCW IQ receive chain: accumulator
//               width agreed with the IQ controller, window state encoding
//               and a width-generic saturating adder.
// Revision    : 1.0 - initial release
// ============================================================================
package sfcw_pkg;

  // Width of the acc_in word the IQ controller consumes.
  localparam int ACC_W = 48;

  // Internal datapath width of sat_add; any accumulator up to SAT_W-1 bits
  // is handled by clamping at the caller-supplied width.
  localparam int SAT_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ACCUM = 2'd2,
    HOLD  = 2'd3
  } acc_state_t;

  typedef struct packed {
    logic                    sat;
    logic signed [SAT_W-1:0] sum;
  } sat_res_t;

  // Signed add of two sign-extended operands, clamped to the range of a
  // 'width'-bit two's-complement number. The result stays sign-extended.
  function automatic sat_res_t sat_add(input logic signed [SAT_W-1:0] a,
                                       input logic signed [SAT_W-1:0] b,
                                       input int unsigned             width);
    logic signed [SAT_W:0] s;
    logic signed [SAT_W:0] one;
    logic signed [SAT_W:0] pos;
    logic signed [SAT_W:0] neg;
    sat_res_t              r;
    one   = {{SAT_W{1'b0}}, 1'b1};
    pos   = (one << (width - 1)) - one;
    neg   = ~pos;
    s     = {a[SAT_W-1], a} + {b[SAT_W-1], b};
    r.sat = 1'b0;
    r.sum = s[SAT_W-1:0];
    if (s > pos) begin
      r.sat = 1'b1;
      r.sum = pos[SAT_W-1:0];
    end else if (s < neg) begin
      r.sat = 1'b1;
      r.sum = neg[SAT_W-1:0];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/signed_mult_reg.sv
`default_nettype none
// ============================================================================
// Module      : signed_mult_reg
// Description : One-stage registered signed multiplier with valid passthrough.
//               flush_i drops whatever enters the stage this cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module signed_mult_reg #(
  parameter int A_W = 16,
  parameter int B_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     valid_i,
  input  logic signed [A_W-1:0]    a_i,
  input  logic signed [B_W-1:0]    b_i,
  output logic                     valid_o,
  output logic signed [A_W+B_W-1:0] p_o
);

  logic                      valid_q;
  logic signed [A_W+B_W-1:0] p_q;

  // Product and its qualifier registered together; flush kills the valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      p_q     <= '0;
    end else begin
      valid_q <= valid_i & ~flush_i;
      p_q     <= a_i * b_i;
    end
  end

  assign valid_o = valid_q;
  assign p_o     = p_q;

endmodule
`default_nettype wire

// File: rtl/iq_window_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : iq_window_accumulator
// Description : Multiplies ADC samples by the LO reference and integrates
//               ACC_LEN products per rf_switch phase after a BLANK_CYC
//               settling blank. The finished window is held on acc_out.
// Revision    : 1.0 - initial release
// ============================================================================
module iq_window_accumulator
  import sfcw_pkg::*;
#(
  parameter int SAMPLE_W  = 16,
  parameter int REF_W     = 16,
  parameter int ACC_W     = sfcw_pkg::ACC_W,
  parameter int BLANK_CYC = 8,
  parameter int ACC_LEN   = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rf_switch,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic signed [REF_W-1:0]    lo_ref,
  output logic signed [ACC_W-1:0]    acc_out,
  output logic                       acc_done,
  output logic                       acc_sat
);

  localparam int PROD_W = SAMPLE_W + REF_W;
  localparam int BLK_CW = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
  localparam int ACC_CW = $clog2(ACC_LEN + 1);

  acc_state_t              state_q, state_d;
  logic                    sw_q;
  logic [BLK_CW-1:0]       blank_cnt_q, blank_cnt_d;
  logic [ACC_CW-1:0]       acc_cnt_q, acc_cnt_d;
  logic signed [SAT_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] acc_out_q, acc_out_d;
  logic                    done_q, done_d;
  logic                    sat_q, sat_d;

  logic                    sw_edge;
  logic                    prod_valid;
  logic signed [PROD_W-1:0] prod;
  logic signed [SAT_W-1:0] prod_ext;
  sat_res_t                add_res;
  logic [BLK_CW-1:0]       blank_nxt;

  assign sw_edge   = rf_switch ^ sw_q;
  assign prod_ext  = {{(SAT_W - PROD_W){prod[PROD_W-1]}}, prod};
  assign add_res   = sat_add(acc_q, prod_ext, ACC_W);
  assign blank_nxt = blank_cnt_q + BLK_CW'(1);

  // An rf_switch edge also flushes the product stage so nothing sampled
  // around the switch moment leaks into the new window.
  signed_mult_reg #(
    .A_W (SAMPLE_W),
    .B_W (REF_W)
  ) u_mult (
    .clk     (clk),
    .rst     (rst),
    .flush_i (sw_edge),
    .valid_i (sample_valid),
    .a_i     (sample),
    .b_i     (lo_ref),
    .valid_o (prod_valid),
    .p_o     (prod)
  );

  // State, counters, accumulator and held result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sw_q        <= rf_switch;
      blank_cnt_q <= '0;
      acc_cnt_q   <= '0;
      acc_q       <= '0;
      acc_out_q   <= '0;
      done_q      <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sw_q        <= rf_switch;
      blank_cnt_q <= blank_cnt_d;
      acc_cnt_q   <= acc_cnt_d;
      acc_q       <= acc_d;
      acc_out_q   <= acc_out_d;
      done_q      <= done_d;
      sat_q       <= sat_d;
    end
  end

  // Window sequencing: an edge restarts everything; the result is published
  // one cycle after the last add, and only if no edge intervened.
  always_comb begin
    state_d     = state_q;
    blank_cnt_d = blank_cnt_q;
    acc_cnt_d   = acc_cnt_q;
    acc_d       = acc_q;
    acc_out_d   = acc_out_q;
    done_d      = done_q;
    sat_d       = sat_q;
    if (sw_edge) begin
      blank_cnt_d = '0;
      acc_cnt_d   = '0;
      acc_d       = '0;
      done_d      = 1'b0;
      sat_d       = 1'b0;
      state_d     = (BLANK_CYC == 0) ? ACCUM : BLANK;
    end else begin
      case (state_q)
        BLANK: begin
          if (prod_valid) begin
            blank_cnt_d = blank_nxt;
            if (blank_nxt == BLK_CW'(BLANK_CYC)) begin
              state_d   = ACCUM;
              acc_d     = '0;
              acc_cnt_d = '0;
            end
          end
        end
        ACCUM: begin
          if (acc_cnt_q == ACC_CW'(ACC_LEN)) begin
            state_d   = HOLD;
            acc_out_d = acc_q[ACC_W-1:0];
            done_d    = 1'b1;
          end else if (prod_valid) begin
            acc_d     = add_res.sum;
            sat_d     = sat_q | add_res.sat;
            acc_cnt_d = acc_cnt_q + ACC_CW'(1);
          end
        end
        IDLE, HOLD: ;
        default: state_d = IDLE;
      endcase
    end
  end

  assign acc_out  = acc_out_q;
  assign acc_done = done_q;
  assign acc_sat  = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_iq_window_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_iq_window_accumulator
// Description : Directed self-checking bench for iq_window_accumulator with a
//               default 48-bit instance and a 36-bit instance for clipping.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iq_window_accumulator;

  logic               clk = 1'b0;
  logic               rst;
  logic               rf_switch;
  logic               sample_valid;
  logic signed [15:0] sample;
  logic signed [15:0] lo_ref;
  logic signed [47:0] acc_out;
  logic               acc_done;
  logic               acc_sat;
  logic signed [35:0] acc_out36;
  logic               acc_done36;
  logic               acc_sat36;

  int total = 0;
  int bad   = 0;
  int k_cyc = 0;
  int stim_mode = 0;

  iq_window_accumulator dut (
    .clk          (clk),
    .rst          (rst),
    .rf_switch    (rf_switch),
    .sample_valid (sample_valid),
    .sample       (sample),
    .lo_ref       (lo_ref),
    .acc_out      (acc_out),
    .acc_done     (acc_done),
    .acc_sat      (acc_sat)
  );

  iq_window_accumulator #(.ACC_W(36)) dut36 (
    .clk          (clk),
    .rst          (rst),
    .rf_switch    (rf_switch),
    .sample_valid (sample_valid),
    .sample       (sample),
    .lo_ref       (lo_ref),
    .acc_out      (acc_out36),
    .acc_done     (acc_done36),
    .acc_sat      (acc_sat36)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sets the inputs for the cycle k_cyc cycles after the latest toggle.
  task automatic drive_cycle();
    case (stim_mode)
      1: begin
        sample_valid = 1'b1;
        lo_ref = (k_cyc % 2 != 0) ? -16'sd1000 : 16'sd1000;
        sample = 16'sd50;
      end
      2: begin
        sample_valid = 1'b1;
        lo_ref = (k_cyc % 2 != 0) ? -16'sd1000 : 16'sd1000;
        sample = (k_cyc % 2 != 0) ? -16'sd50 : 16'sd50;
      end
      3: begin
        sample_valid = (k_cyc % 3 == 0);
        sample = 16'(k_cyc + 1);
        lo_ref = 16'sd10;
      end
      default: ;
    endcase
  endtask

  // Toggles rf_switch and waits for acc_done; lat = -1 if the bound expires.
  task automatic run_window(input int bound, output int lat,
                            output logic first_done, output logic first_sat36);
    k_cyc = 0;
    rf_switch = ~rf_switch;
    drive_cycle();
    lat = -1;
    first_done = 1'b1;
    first_sat36 = 1'b1;
    for (int i = 1; i <= bound; i++) begin
      step();
      k_cyc = i;
      if (i == 1) begin
        first_done = acc_done;
        first_sat36 = acc_sat36;
      end
      if (acc_done) begin
        lat = i;
        break;
      end
      drive_cycle();
    end
  endtask

  task automatic test_reset();
    int early;
    rst = 1'b1; rf_switch = 1'b0; sample_valid = 1'b0; sample = '0; lo_ref = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    total++; if (acc_out !== 48'sd0) begin bad++; $display("FAIL reset_acc_out: got %0d expected 0", acc_out); end
    total++; if (acc_done !== 1'b0) begin bad++; $display("FAIL reset_acc_done: got %b expected 0", acc_done); end
    total++; if (acc_sat !== 1'b0) begin bad++; $display("FAIL reset_acc_sat: got %b expected 0", acc_sat); end
    sample_valid = 1'b1; sample = 16'sd100; lo_ref = 16'sd200;
    early = 0;
    repeat (100) begin step(); if (acc_done) early++; end
    total++; if (early !== 0) begin bad++; $display("FAIL idle_no_window: got %0d done cycles expected 0", early); end
  endtask

  task automatic test_basic();
    int lat; logic fd; logic fs;
    stim_mode = 0; sample_valid = 1'b1; sample = 16'sd100; lo_ref = 16'sd200;
    run_window(200, lat, fd, fs);
    total++; if (lat !== 75) begin bad++; $display("FAIL basic_latency: got %0d expected 75", lat); end
    total++; if (acc_out !== 48'sd1280000) begin bad++; $display("FAIL basic_acc_out: got %0d expected 1280000", acc_out); end
    total++; if (acc_sat !== 1'b0) begin bad++; $display("FAIL basic_acc_sat: got %b expected 0", acc_sat); end
  endtask

  task automatic test_alternating();
    int lat; logic fd; logic fs;
    stim_mode = 1;
    run_window(200, lat, fd, fs);
    total++; if (fd !== 1'b0) begin bad++; $display("FAIL alt_done_fall: got %b expected 0", fd); end
    total++; if (lat !== 75) begin bad++; $display("FAIL alt_latency: got %0d expected 75", lat); end
    total++; if (acc_out !== 48'sd0) begin bad++; $display("FAIL alt_acc_out: got %0d expected 0", acc_out); end
    stim_mode = 2;
    run_window(200, lat, fd, fs);
    total++; if (lat !== 75) begin bad++; $display("FAIL inphase_latency: got %0d expected 75", lat); end
    total++; if (acc_out !== 48'sd3200000) begin bad++; $display("FAIL inphase_acc_out: got %0d expected 3200000", acc_out); end
    stim_mode = 0;
  endtask

  task automatic test_restart();
    int lat; int held_bad;
    stim_mode = 0; sample_valid = 1'b1; sample = 16'sd7; lo_ref = 16'sd1000;
    rf_switch = ~rf_switch;
    held_bad = 0;
    repeat (40) begin
      step();
      if (acc_done !== 1'b0 || acc_out !== 48'sd3200000) held_bad++;
    end
    rf_switch = ~rf_switch; sample = 16'sd3;
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (acc_done) begin lat = i; break; end
      if (acc_out !== 48'sd3200000) held_bad++;
    end
    total++; if (held_bad !== 0) begin bad++; $display("FAIL restart_hold: got %0d bad cycles expected 0", held_bad); end
    total++; if (lat !== 75) begin bad++; $display("FAIL restart_latency: got %0d expected 75", lat); end
    total++; if (acc_out !== 48'sd192000) begin bad++; $display("FAIL restart_acc_out: got %0d expected 192000", acc_out); end
  endtask

  task automatic test_sparse();
    int lat; logic fd; logic fs;
    stim_mode = 3;
    run_window(400, lat, fd, fs);
    total++; if (lat !== 219) begin bad++; $display("FAIL sparse_latency: got %0d expected 219", lat); end
    total++; if (acc_out !== 48'sd78400) begin bad++; $display("FAIL sparse_acc_out: got %0d expected 78400", acc_out); end
    stim_mode = 0; sample_valid = 1'b1;
  endtask

  task automatic test_saturation();
    int lat; logic fd; logic fs;
    stim_mode = 0; sample_valid = 1'b1; sample = 16'sd32767; lo_ref = 16'sd32767;
    run_window(200, lat, fd, fs);
    total++; if (acc_out36 !== 36'sh7FFFFFFFF) begin bad++; $display("FAIL sat_pos_acc_out36: got %0d expected 34359738367", acc_out36); end
    total++; if (acc_sat36 !== 1'b1) begin bad++; $display("FAIL sat_pos_flag36: got %b expected 1", acc_sat36); end
    total++; if (acc_out !== 48'sd68715282496) begin bad++; $display("FAIL nosat_pos_acc_out48: got %0d expected 68715282496", acc_out); end
    total++; if (acc_sat !== 1'b0) begin bad++; $display("FAIL nosat_pos_flag48: got %b expected 0", acc_sat); end
    lo_ref = -16'sd32768;
    run_window(200, lat, fd, fs);
    total++; if (fs !== 1'b0) begin bad++; $display("FAIL sat_clear_on_edge: got %b expected 0", fs); end
    total++; if (acc_out36 !== 36'sh800000000) begin bad++; $display("FAIL sat_neg_acc_out36: got %0d expected -34359738368", acc_out36); end
    total++; if (acc_sat36 !== 1'b1) begin bad++; $display("FAIL sat_neg_flag36: got %b expected 1", acc_sat36); end
    total++; if (acc_out !== -48'sd68717379584) begin bad++; $display("FAIL nosat_neg_acc_out48: got %0d expected -68717379584", acc_out); end
    sample = 16'sd1; lo_ref = 16'sd1;
    run_window(200, lat, fd, fs);
    total++; if (fs !== 1'b0) begin bad++; $display("FAIL sat_clear_after_neg: got %b expected 0", fs); end
    total++; if (acc_sat36 !== 1'b0 || acc_out36 !== 36'sd64) begin bad++; $display("FAIL small_window36: got %0d sat %b expected 64 sat 0", acc_out36, acc_sat36); end
  endtask

  task automatic test_reset_mid();
    int lat; int early; logic fd; logic fs;
    stim_mode = 0; sample_valid = 1'b1; sample = 16'sd5; lo_ref = 16'sd5;
    rf_switch = ~rf_switch;
    repeat (40) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (acc_out !== 48'sd0 || acc_done !== 1'b0 || acc_sat !== 1'b0) begin bad++; $display("FAIL rst_mid_outputs: got %0d done %b sat %b expected 0 0 0", acc_out, acc_done, acc_sat); end
    early = 0;
    repeat (100) begin step(); if (acc_done) early++; end
    total++; if (early !== 0) begin bad++; $display("FAIL rst_mid_no_window: got %0d done cycles expected 0", early); end
    run_window(200, lat, fd, fs);
    total++; if (lat !== 75) begin bad++; $display("FAIL rst_mid_latency: got %0d expected 75", lat); end
    total++; if (acc_out !== 48'sd1600) begin bad++; $display("FAIL rst_mid_acc_out: got %0d expected 1600", acc_out); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_alternating();
    test_restart();
    test_sparse();
    test_saturation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
